// File: rtl/instr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq_pkg
// Purpose  : Shared types and helpers for the instruction sequencer.
//            - dir_t        : motion direction encoding
//            - state_t      : sequencer FSM states
//            - torque_split : per-wheel torque gating for a direction
// Revision : 1.0  initial parametrised release
// ============================================================================
package instr_seq_pkg;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'b00,
    DIR_REV   = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Returns {left, right} for one torque bit. Callers apply it bit by bit
  // across the torque field, which keeps the helper independent of the
  // torque width. Turning left idles the left wheel; turning right idles
  // the right wheel; straight motion drives both.
  function automatic logic [1:0] torque_split(input dir_t dir, input logic t);
    logic l;
    logic r;
    l = t;
    r = t;
    case (dir)
      DIR_LEFT:  l = 1'b0;
      DIR_RIGHT: r = 1'b0;
      default:   ;
    endcase
    return {l, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_store.sv
`default_nettype none
// ============================================================================
// Module   : instr_store
// Purpose  : DEPTH-entry instruction register array. Appends at the tail,
//            deletes from the tail (LIFO delete) and is read by index from
//            the head (FIFO-order playback).
// Ports    : clk, rst        - clock, async active-high reset
//            wr_en           - append {wr_dir, wr_torque} (ignored when full)
//            del_en          - drop newest entry (ignored when empty, wins
//                              over wr_en)
//            rd_idx          - playback index; rd_dir/rd_torque combinational
//            count/full/empty- occupancy
// Revision : 1.0  initial release
// ============================================================================
module instr_store
  import instr_seq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TORQUE_W = 2,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                del_en,
  input  logic [1:0]          wr_dir,
  input  logic [TORQUE_W-1:0] wr_torque,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [1:0]          rd_dir,
  output logic [TORQUE_W-1:0] rd_torque,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  logic [1:0]          mem_dir_q [DEPTH];
  logic [TORQUE_W-1:0] mem_tq_q  [DEPTH];
  logic [CNT_W-1:0]    count_d;
  logic [CNT_W-1:0]    count_q;
  logic                wr_take;
  logic                del_take;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign del_take  = del_en && !empty;
  assign wr_take   = wr_en && !full && !del_en;

  always_comb begin
    count_d = count_q;
    if (del_take) begin
      count_d = count_q - CNT_W'(1);
    end else if (wr_take) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries at or above count are never read.
  // When not full, count_q < DEPTH so the low bits address the tail slot.
  always_ff @(posedge clk) begin
    if (wr_take) begin
      mem_dir_q[count_q[IDX_W-1:0]] <= wr_dir;
      mem_tq_q[count_q[IDX_W-1:0]]  <= wr_torque;
    end
  end

  assign rd_dir    = mem_dir_q[rd_idx];
  assign rd_torque = mem_tq_q[rd_idx];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Records up to DEPTH motion instructions (direction + torque)
//            from debounced save pulses and replays them in order, each for
//            STEP_CYCLES clocks, driving per-wheel torque.
// Ports    : CLOCK50, reset (async active-high)
//            save_pulse / delete_pulse / exec_pulse - one-cycle requests,
//              priority exec > delete > save, honoured only while idle
//            instr_dir, instr_torque - instruction to append
//            busy, active_valid, active_dir, left_torque, right_torque,
//              done_pulse - registered playback outputs
//            count, full, empty - store occupancy
// Option   : INSTR_SEQ_LOOP_EN adds loop_mode: playback wraps to entry 0
//            with a done_pulse at every wrap; exec_pulse while looping stops.
// Revision : 1.0  initial parametrised release
// ============================================================================
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TORQUE_W    = 2,
  parameter int STEP_CYCLES = 50_000_000,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic                CLOCK50,
  input  logic                reset,
  input  logic                save_pulse,
  input  logic                exec_pulse,
  input  logic                delete_pulse,
  input  logic [1:0]          instr_dir,
  input  logic [TORQUE_W-1:0] instr_torque,
`ifdef INSTR_SEQ_LOOP_EN
  input  logic                loop_mode,
`endif
  output logic                busy,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  output logic [1:0]          active_dir,
  output logic                active_valid,
  output logic [TORQUE_W-1:0] left_torque,
  output logic [TORQUE_W-1:0] right_torque,
  output logic                done_pulse
);

  localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] STEP_LAST = TIMER_W'(STEP_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic [TIMER_W-1:0]  timer_q,  timer_d;
  logic                busy_q,   busy_d;
  logic                valid_q,  valid_d;
  logic [1:0]          dir_q,    dir_d;
  logic [TORQUE_W-1:0] left_q,   left_d;
  logic [TORQUE_W-1:0] right_q,  right_d;
  logic                done_q,   done_d;

  // --------------------------------------------------------------------------
  // Control strobes
  // --------------------------------------------------------------------------
  logic                load_out;   // present entry idx_d on the outputs
  logic                clear_out;  // drop back to idle output values
  logic                st_wr;
  logic                st_del;
  logic                loop_en;
  logic                last_idx;
  logic [1:0]          rd_dir;
  logic [TORQUE_W-1:0] rd_torque;
  logic [CNT_W-1:0]    count_w;
  logic                full_w;
  logic                empty_w;

`ifdef INSTR_SEQ_LOOP_EN
  assign loop_en = loop_mode;
`else
  assign loop_en = 1'b0;
`endif

  assign last_idx = ({1'b0, idx_q} == (count_w - CNT_W'(1)));

  // --------------------------------------------------------------------------
  // Instruction store
  // --------------------------------------------------------------------------
  // The read index is the *next* index so the registered outputs show the
  // new entry on the same edge the index advances.
  instr_store #(
    .DEPTH    (DEPTH),
    .TORQUE_W (TORQUE_W)
  ) u_store (
    .clk       (CLOCK50),
    .rst       (reset),
    .wr_en     (st_wr),
    .del_en    (st_del),
    .wr_dir    (instr_dir),
    .wr_torque (instr_torque),
    .rd_idx    (idx_d),
    .rd_dir    (rd_dir),
    .rd_torque (rd_torque),
    .count     (count_w),
    .full      (full_w),
    .empty     (empty_w)
  );

  // --------------------------------------------------------------------------
  // Sequencing: state, index, step timer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    load_out  = 1'b0;
    clear_out = 1'b0;
    st_wr     = 1'b0;
    st_del    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (exec_pulse) begin
          // Exec on an empty store is swallowed; it still blocks save/delete.
          if (!empty_w) begin
            state_d  = S_RUN;
            idx_d    = '0;
            timer_d  = '0;
            load_out = 1'b1;
          end
        end else if (delete_pulse) begin
          st_del = 1'b1;
        end else if (save_pulse) begin
          st_wr = 1'b1;
        end
      end

      S_RUN: begin
        if (loop_en && exec_pulse) begin
          // Only a looping run can be stopped; no completion is signalled.
          state_d   = S_IDLE;
          idx_d     = '0;
          timer_d   = '0;
          clear_out = 1'b1;
        end else if (timer_q == STEP_LAST) begin
          timer_d = '0;
          if (last_idx) begin
            done_d = 1'b1;
            idx_d  = '0;
            if (loop_en) begin
              load_out = 1'b1;
            end else begin
              state_d   = S_IDLE;
              clear_out = 1'b1;
            end
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            load_out = 1'b1;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        clear_out = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output next-state
  // --------------------------------------------------------------------------
  always_comb begin
    logic [1:0] lr;
    lr      = '0;
    busy_d  = busy_q;
    valid_d = valid_q;
    dir_d   = dir_q;
    left_d  = left_q;
    right_d = right_q;

    if (clear_out) begin
      busy_d  = 1'b0;
      valid_d = 1'b0;
      dir_d   = 2'b00;
      left_d  = '0;
      right_d = '0;
    end else if (load_out) begin
      busy_d  = 1'b1;
      valid_d = 1'b1;
      dir_d   = rd_dir;
      for (int b = 0; b < TORQUE_W; b++) begin
        lr         = torque_split(dir_t'(rd_dir), rd_torque[b]);
        left_d[b]  = lr[1];
        right_d[b] = lr[0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dir_q   <= 2'b00;
      left_q  <= '0;
      right_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      left_q  <= left_d;
      right_q <= right_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign active_valid = valid_q;
  assign active_dir   = dir_q;
  assign left_torque  = left_q;
  assign right_torque = right_q;
  assign done_pulse   = done_q;
  assign count        = count_w;
  assign full         = full_w;
  assign empty        = empty_w;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Directed self-checking bench for instr_sequencer with
//            DEPTH=8, TORQUE_W=2, STEP_CYCLES=10. Inputs change and outputs
//            are sampled on the falling clock edge.
//            Output vector checked per step: {busy, active_valid,
//            active_dir[1:0], left_torque[1:0], right_torque[1:0]}.
// Option   : INSTR_SEQ_LOOP_EN enables the loop_mode scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int STEP = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       save_pulse;
  logic       exec_pulse;
  logic       delete_pulse;
  logic [1:0] instr_dir;
  logic [1:0] instr_torque;
`ifdef INSTR_SEQ_LOOP_EN
  logic       loop_mode;
`endif
  logic       busy;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic [1:0] active_dir;
  logic       active_valid;
  logic [1:0] left_torque;
  logic [1:0] right_torque;
  logic       done_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;

  always #5 clk = ~clk;

  instr_sequencer #(
    .DEPTH       (8),
    .TORQUE_W    (2),
    .STEP_CYCLES (STEP)
  ) dut (
    .CLOCK50      (clk),
    .reset        (reset),
    .save_pulse   (save_pulse),
    .exec_pulse   (exec_pulse),
    .delete_pulse (delete_pulse),
    .instr_dir    (instr_dir),
    .instr_torque (instr_torque),
`ifdef INSTR_SEQ_LOOP_EN
    .loop_mode    (loop_mode),
`endif
    .busy         (busy),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .active_dir   (active_dir),
    .active_valid (active_valid),
    .left_torque  (left_torque),
    .right_torque (right_torque),
    .done_pulse   (done_pulse)
  );

  // Count completion pulses, sampled safely after each rising edge.
  always @(posedge clk) begin
    #1;
    if (done_pulse === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outv();
    return {busy, active_valid, active_dir, left_torque, right_torque};
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_save(input logic [1:0] d, input logic [1:0] t);
    instr_dir    = d;
    instr_torque = t;
    save_pulse   = 1'b1;
    @(negedge clk);
    save_pulse   = 1'b0;
  endtask

  task automatic pulse_exec();
    exec_pulse = 1'b1;
    @(negedge clk);
    exec_pulse = 1'b0;
  endtask

  task automatic pulse_delete();
    delete_pulse = 1'b1;
    @(negedge clk);
    delete_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Watchdog: the directed flow is fixed-length, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] exp1 [5];
    exp1[0] = 8'hC0;  // fwd t0 : 0/0
    exp1[1] = 8'hC5;  // fwd t1 : 1/1
    exp1[2] = 8'hCA;  // fwd t2 : 2/2
    exp1[3] = 8'hCF;  // fwd t3 : 3/3
    exp1[4] = 8'hE3;  // left t3: 0/3

    reset        = 1'b1;
    save_pulse   = 1'b0;
    exec_pulse   = 1'b0;
    delete_pulse = 1'b0;
    instr_dir    = 2'b00;
    instr_torque = 2'b00;
`ifdef INSTR_SEQ_LOOP_EN
    loop_mode    = 1'b0;
`endif
    wait_n(2);

    // ---------------- reset state ----------------
    check("rst_out",   32'(outv()), 32'h00);
    check("rst_count", 32'(count), 0);
    check("rst_flags", 32'({full, empty, done_pulse}), 32'b010);
    reset = 1'b0;
    wait_n(1);

    // ---------------- basic playback ----------------
    pulse_save(2'b00, 2'd0);
    pulse_save(2'b00, 2'd1);
    pulse_save(2'b00, 2'd2);
    pulse_save(2'b00, 2'd3);
    pulse_save(2'b10, 2'd3);
    check("t1_count", 32'(count), 5);
    d0 = done_cnt;
    pulse_exec();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t1_step%0d", k), 32'(outv()), 32'(exp1[k]));
      if (k < 4) wait_n(STEP);
    end
    wait_n(STEP - 1);
    check("t1_last_cycle", 32'({outv(), done_pulse}), 32'({8'hE3, 1'b0}));
    wait_n(1);
    check("t1_end", 32'({outv(), done_pulse}), 32'({8'h00, 1'b1}));
    wait_n(1);
    check("t1_done_once", 32'(done_cnt - d0), 1);
    check("t1_count_kept", 32'(count), 5);

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 0; i < 8; i++) pulse_save(2'b01, 2'(i));
    check("t2_full8", 32'({count, full, empty}), 32'({4'd8, 1'b1, 1'b0}));
    pulse_save(2'b10, 2'd1);
    check("t2_full9", 32'({count, full, empty}), 32'({4'd8, 1'b1, 1'b0}));
    pulse_exec();
    check("t2_step0", 32'(outv()), 32'h D0);
    wait_n(7 * STEP);
    check("t2_step7", 32'(outv()), 32'h DF);
    wait_n(STEP);
    check("t2_end", 32'({outv(), done_pulse}), 32'({8'h00, 1'b1}));

    // ---------------- delete then append, RUN ignores requests ----------------
    do_reset();
    pulse_save(2'b00, 2'd1);
    pulse_save(2'b01, 2'd2);
    pulse_save(2'b10, 2'd3);
    pulse_delete();
    check("t3_after_del", 32'(count), 2);
    pulse_save(2'b11, 2'd2);
    check("t3_after_save", 32'(count), 3);
    pulse_exec();                       // now at step-time 0.5
    check("t3_step0", 32'(outv()), 32'hC5);
    pulse_save(2'b00, 2'd3);            // 1.5
    pulse_delete();                     // 2.5
    pulse_exec();                       // 3.5
    check("t3_run_ignores", 32'({count, outv()}), 32'({4'd3, 8'hC5}));
    wait_n(STEP - 3);
    check("t3_step1", 32'(outv()), 32'hDA);
    wait_n(STEP);
    check("t3_step2", 32'(outv()), 32'hF8);
    wait_n(STEP);
    check("t3_end", 32'({outv(), done_pulse}), 32'({8'h00, 1'b1}));

    // ---------------- empty exec and priorities ----------------
    do_reset();
    d0 = done_cnt;
    pulse_exec();
    check("t4_exec_empty", 32'(outv()), 32'h00);
    wait_n(3);
    check("t4_no_done", 32'(done_cnt - d0), 0);
    pulse_delete();
    check("t4_del_empty", 32'({count, empty}), 32'({4'd0, 1'b1}));
    save_pulse = 1'b1; exec_pulse = 1'b1; instr_dir = 2'b00; instr_torque = 2'd1;
    @(negedge clk);
    save_pulse = 1'b0; exec_pulse = 1'b0;
    check("t4_exec_over_save", 32'({count, busy}), 32'({4'd0, 1'b0}));
    pulse_save(2'b00, 2'd1);
    save_pulse = 1'b1; delete_pulse = 1'b1;
    @(negedge clk);
    save_pulse = 1'b0; delete_pulse = 1'b0;
    check("t4_del_over_save", 32'(count), 0);
    pulse_save(2'b11, 2'd2);
    exec_pulse = 1'b1; delete_pulse = 1'b1;
    @(negedge clk);
    exec_pulse = 1'b0; delete_pulse = 1'b0;
    check("t4_exec_over_del", 32'({count, outv()}), 32'({4'd1, 8'hF8}));
    wait_n(STEP);
    check("t4_single_end", 32'({count, outv(), done_pulse}), 32'({4'd1, 8'h00, 1'b1}));

    // ---------------- reset mid-run ----------------
    do_reset();
    pulse_save(2'b00, 2'd1);
    pulse_save(2'b00, 2'd2);
    pulse_exec();
    wait_n(15);
    check("t5_before_rst", 32'(outv()), 32'hCA);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check("t5_async_rst", 32'({count, outv(), done_pulse}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_n(3 * STEP);
    check("t5_no_done", 32'({done_cnt - d0, 32'(busy)}), 0);

`ifdef INSTR_SEQ_LOOP_EN
    // ---------------- loop mode ----------------
    do_reset();
    loop_mode = 1'b1;
    pulse_save(2'b00, 2'd1);
    pulse_save(2'b10, 2'd2);
    d0 = done_cnt;
    pulse_exec();
    check("t6_step0", 32'(outv()), 32'hC5);
    wait_n(STEP);
    check("t6_step1", 32'(outv()), 32'hE2);
    wait_n(STEP);
    check("t6_wrap1", 32'({outv(), done_pulse}), 32'({8'hC5, 1'b1}));
    wait_n(2 * STEP);
    check("t6_wrap2", 32'({outv(), done_pulse}), 32'({8'hC5, 1'b1}));
    pulse_exec();
    check("t6_stop", 32'({outv(), done_pulse}), 32'({8'h00, 1'b0}));
    check("t6_done_cnt", 32'(done_cnt - d0), 2);
    loop_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
